// File: rtl/sbus_ram.sv
// -----------------------------------------------------------------------------
// sbus_ram -- word-addressed RAM responder terminating one sbus slave port.
//
// Serves the instruction or data master of the mips core in simulation and
// FPGA bring-up.  Every request is stretched by LATENCY wait states so that
// the core's stall handling is exercised.  The read or write takes effect
// in the cycle where stall drops (the completion cycle).
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  stall cycles before each transfer completes (0..15)
//   BASE     byte address of word 0 (aligned to DEPTH*4)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   sbus_s_en     request valid, held by the master until after completion
//   sbus_s_addr   byte address, bits [1:0] ignored
//   sbus_s_we     byte write mask, 4'b0000 = read
//   sbus_s_wdata  write data
//   sbus_s_rdata  read data, non-zero only in the completion cycle
//   sbus_s_stall  wait request
//   err           sticky out-of-range flag
//
// Build option
//   SBUS_RAM_BOUNDS_EN  when defined, addresses outside [BASE, BASE+DEPTH*4)
//                       complete normally but read 0, do not write, and set
//                       err until reset.  When undefined the index wraps
//                       modulo DEPTH and err is tied low.
// -----------------------------------------------------------------------------
module sbus_ram #(
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sbus_s_en,
  input  logic [31:0] sbus_s_addr,
  input  logic [3:0]  sbus_s_we,
  input  logic [31:0] sbus_s_wdata,
  output logic [31:0] sbus_s_rdata,
  output logic        sbus_s_stall,
  output logic        err
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = LATENCY[3:0];

`ifdef SBUS_RAM_BOUNDS_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Address decode.  Subtracting BASE first makes addresses below BASE wrap to
  // large offsets, so a single "upper offset bits are zero" test covers both
  // ends of the window.
  // ---------------------------------------------------------------------------
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          hit;
  logic [1:0]    unused_lsb;

  always_comb begin
    off        = sbus_s_addr - BASE;
    idx        = off[AW+1:2];
    in_range   = (off[31:AW+2] == '0);
    unused_lsb = off[1:0];
    // Without bounds checking every address aliases into the array.
    hit        = in_range | ~BOUNDS_EN;
  end

  // ---------------------------------------------------------------------------
  // Wait-state counter.  The IDLE/WAIT/DONE states are implied by cnt and en:
  // DONE is the combinational cycle where cnt has reached LAT.
  // ---------------------------------------------------------------------------
  logic [3:0] cnt_q, cnt_d;
  logic       complete;

  always_comb begin
    sbus_s_stall = sbus_s_en && (cnt_q != LAT);
    complete     = sbus_s_en && !sbus_s_stall;
    // Counting only while stalled; a dropped en (abort) or a completion both
    // send the counter back to 0 so the next request pays the full latency.
    cnt_d = '0;
    if (sbus_s_stall) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Storage: asynchronous read, synchronous byte-lane write.  rdata carries the
  // pre-write contents (read-first).  Reset takes priority over a completion.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];
  logic        wr_en;

  always_comb begin
    wr_en        = complete && hit && (sbus_s_we != 4'b0000);
    sbus_s_rdata = '0;
    if (complete && hit) sbus_s_rdata = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sbus_s_we[i]) mem[idx][8*i +: 8] <= sbus_s_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky out-of-range flag.
  // ---------------------------------------------------------------------------
`ifdef SBUS_RAM_BOUNDS_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (complete & ~in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sbus_ram.sv
// -----------------------------------------------------------------------------
// tb_sbus_ram -- directed self-checking bench for sbus_ram.
// One instance runs with LATENCY=2, a second with LATENCY=0.  Window is
// BASE=0x1000, DEPTH=1024, so BASE+DEPTH*4 = 0x2000 aliases to word 0 when
// bounds checking is off.
// -----------------------------------------------------------------------------
module tb_sbus_ram;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;

  logic        en, en0;
  logic [31:0] addr, addr0;
  logic [3:0]  we, we0;
  logic [31:0] wdata, wdata0;
  logic [31:0] rdata, rdata0;
  logic        stall, stall0;
  logic        err, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sbus_ram #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u_ram (
    .clk(clk), .rst(rst),
    .sbus_s_en(en), .sbus_s_addr(addr), .sbus_s_we(we), .sbus_s_wdata(wdata),
    .sbus_s_rdata(rdata), .sbus_s_stall(stall), .err(err)
  );

  sbus_ram #(.DEPTH(DEPTH), .LATENCY(0), .BASE(BASE)) u_ram0 (
    .clk(clk), .rst(rst),
    .sbus_s_en(en0), .sbus_s_addr(addr0), .sbus_s_we(we0), .sbus_s_wdata(wdata0),
    .sbus_s_rdata(rdata0), .sbus_s_stall(stall0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request on the LATENCY=2 port and walks it to completion.
  // Inputs change just after posedge; outputs are sampled on negedge.
  // en is left high so callers can chain back-to-back requests.
  task automatic xfer(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                      input bit chk_rd, input logic [31:0] exp, input string tag);
    en = 1'b1; addr = a; we = w; wdata = d;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("%s stall c%0d", tag, k), {31'b0, stall}, {31'b0, (k < 2)});
      if (k < 2)       chk($sformatf("%s rdata0 c%0d", tag, k), rdata, 32'h0);
      else if (chk_rd) chk($sformatf("%s rdata", tag), rdata, exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input string tag);
    en = 1'b0; we = 4'h0;
    @(negedge clk);
    chk({tag, " idle stall"}, {31'b0, stall}, 32'h0);
    chk({tag, " idle rdata"}, rdata, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; addr = BASE; we = 4'h0; wdata = '0;
    en0 = 1'b0; addr0 = BASE; we0 = 4'h0; wdata0 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset stall", {31'b0, stall}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset err",   {31'b0, err},   32'h0);
    chk("reset stall0", {31'b0, stall0}, 32'h0);
    @(posedge clk); #1;

    // Full write then read back
    xfer(BASE + 4, 4'hF, 32'h1234_5678, 1'b0, '0, "wr1");
    idle("wr1");
    xfer(BASE + 4, 4'h0, '0, 1'b1, 32'h1234_5678, "rd1");
    idle("rd1");

    // Single byte lane
    xfer(BASE + 4, 4'b0010, 32'hAABB_CCDD, 1'b0, '0, "wr2");
    idle("wr2");
    xfer(BASE + 4, 4'h0, '0, 1'b1, 32'h1234_CC78, "rd2");
    idle("rd2");

    // Abort after one stall cycle: nothing written, next request full latency
    en = 1'b1; addr = BASE + 4; we = 4'hF; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("abort stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    idle("abort");
    xfer(BASE + 4, 4'h0, '0, 1'b1, 32'h1234_CC78, "rd_after_abort");
    idle("rd_after_abort");

    // Back-to-back reads with en held high throughout
    xfer(BASE + 8, 4'hF, 32'hCAFE_F00D, 1'b0, '0, "wr3");
    idle("wr3");
    xfer(BASE + 4, 4'h0, '0, 1'b1, 32'h1234_CC78, "b2b0");
    xfer(BASE + 8, 4'h0, '0, 1'b1, 32'hCAFE_F00D, "b2b1");
    xfer(BASE + 4, 4'h0, '0, 1'b1, 32'h1234_CC78, "b2b2");
    idle("b2b");

    // rst during WAIT aborts; stall restarts from cnt=0 afterwards
    en = 1'b1; addr = BASE + 8; we = 4'hF; wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;            // cnt = 1
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(BASE + 8, 4'h0, '0, 1'b1, 32'hCAFE_F00D, "rst_wait restart");
    idle("rst_wait");

    // rst coincident with completion suppresses the write
    en = 1'b1; addr = BASE + 8; we = 4'hF; wdata = 32'h5555_AAAA;
    repeat (2) begin @(posedge clk); #1; end   // now in DONE
    rst = 1'b1;
    @(negedge clk);
    chk("rst_done stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle("rst_done");
    xfer(BASE + 8, 4'h0, '0, 1'b1, 32'hCAFE_F00D, "rst_done read");
    idle("rst_done read");

    // LATENCY=0: one completion per cycle
    en0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr0 = BASE + 32'(4 * i); we0 = 4'hF; wdata0 = 32'h1111_1111 * 32'(i + 1);
      @(negedge clk);
      chk($sformatf("lat0 wr%0d stall", i), {31'b0, stall0}, 32'h0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      addr0 = BASE + 32'(4 * i); we0 = 4'h0;
      @(negedge clk);
      chk($sformatf("lat0 rd%0d stall", i), {31'b0, stall0}, 32'h0);
      chk($sformatf("lat0 rd%0d rdata", i), rdata0, 32'h1111_1111 * 32'(i + 1));
      @(posedge clk); #1;
    end
    en0 = 1'b0;

    // Out-of-range access at BASE+DEPTH*4
    xfer(BASE, 4'hF, 32'h0102_0304, 1'b0, '0, "w0");
    idle("w0");
    xfer(BASE + DEPTH * 4, 4'hF, 32'hDEAD_BEEF, 1'b0, '0, "oor wr");
    idle("oor wr");
`ifdef SBUS_RAM_BOUNDS_EN
    chk("oor err", {31'b0, err}, 32'h1);
    xfer(BASE, 4'h0, '0, 1'b1, 32'h0102_0304, "oor word0");
    idle("oor word0");
    xfer(BASE + DEPTH * 4, 4'h0, '0, 1'b1, 32'h0, "oor rd");
    idle("oor rd");
    chk("oor err sticky", {31'b0, err}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("oor err cleared", {31'b0, err}, 32'h0);
`else
    chk("wrap err", {31'b0, err}, 32'h0);
    xfer(BASE, 4'h0, '0, 1'b1, 32'hDEAD_BEEF, "wrap word0");
    idle("wrap word0");
    xfer(BASE + DEPTH * 4, 4'h0, '0, 1'b1, 32'hDEAD_BEEF, "wrap rd");
    idle("wrap rd");
    chk("wrap err after", {31'b0, err}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
